neural_sim_ctrl: RTL and testbench
==================================

# neural_sim_ctrl

Run scheduler for the dataset replay source (NeuralSim_Mem / NeuralSim_Mod) in the FPGA simulation path. It replaces hand-written reset/enable sequencing with a programmable sequence: reset pulse, stream until end-of-data, inter-run gap, then repeat for N runs or continuously. It forwards the source's sample and trigger outputs with a valid qualifier, counts runs and trigger events, and supports abort. It sits between the replay source and downstream consumers (spike detector, framing, host readout).

## Interface
- RST_CYC, 6: length in cycles of the source reset pulse (≥1).
- CNT_WIDTH, 16: width of SPIKE_CNT.
- CLK_ADC  in  1  sampling clock; all logic on rising edge.
- nRST  in  1  one clock; reset is synchronous and active-low.
- START  in  1  begin a sequence; honoured only in IDLE.
- ABORT  in  1  terminate the active sequence.
- NUM_RUNS  in  8  number of runs; 0 = continuous until ABORT; latched on START.
- GAP_CYC  in  16  idle cycles between runs; latched on START.
- SRC_DATA  in  12 signed  source sample.
- SRC_TRGG  in  1  source trigger/spike marker.
- SRC_END  in  1  source end-of-dataset flag.
- SRC_nRST  out  1  source reset, active-low.
- SRC_EN  out  1  source enable.
- DATA_OUT  out  12 signed  registered copy of SRC_DATA.
- DATA_VALID  out  1  DATA_OUT holds a streamed sample.
- TRGG_OUT  out  1  registered SRC_TRGG, qualified by DATA_VALID.
- RUN_CNT  out  8  completed runs in the current sequence.
- SPIKE_CNT  out  CNT_WIDTH  SRC_TRGG count over the sequence, saturating.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when a sequence ends.
- ABORTED  out  1  last sequence ended by ABORT; cleared on next START.

## Operation
- States: IDLE, SRC_RST, STREAM, GAP, FINISH.
- IDLE: SRC_nRST=0, SRC_EN=0. On START, latch NUM_RUNS and GAP_CYC, clear RUN_CNT, SPIKE_CNT and ABORTED, then go to SRC_RST.
- SRC_RST: SRC_nRST=0 for exactly RST_CYC cycles, then go to STREAM.
- STREAM: SRC_nRST=1, SRC_EN=1. Each cycle with SRC_END=0:
  - DATA_OUT<=SRC_DATA, DATA_VALID<=1, TRGG_OUT<=SRC_TRGG.
  - SPIKE_CNT increments on SRC_TRGG and saturates at all-ones.
- End of run: SRC_END=1 in STREAM.
  - That sample is not forwarded; SRC_EN drops the next cycle and RUN_CNT increments (8-bit wrap allowed only when NUM_RUNS=0).
  - If the incremented RUN_CNT equals a nonzero NUM_RUNS, go to FINISH.
  - Otherwise go to GAP, or directly to SRC_RST if GAP_CYC=0.
- GAP: SRC_nRST=1, SRC_EN=0 for GAP_CYC cycles, then go to SRC_RST.
- FINISH: SRC_nRST=0, SRC_EN=0, DONE=1 for one cycle, then go to IDLE.
- DATA_VALID and TRGG_OUT are 0 outside STREAM forwarding cycles. DATA_OUT holds its last value.
- ABORT: in SRC_RST, STREAM or GAP, go to FINISH next cycle and set ABORTED=1. In STREAM, a sample arriving on the ABORT cycle is still forwarded. ABORT in IDLE or FINISH is ignored.
- Simultaneous events:
  - ABORT has priority over SRC_END; RUN_CNT is not incremented.
  - START in FINISH or while BUSY is ignored.
- SRC_END already high on the first STREAM cycle: counts as an empty run, with normal end-of-run handling.

## Timing
- Reset (nRST=0 at a clock edge): state IDLE.
  - SRC_nRST=0, SRC_EN=0, DATA_OUT=0, DATA_VALID=0, TRGG_OUT=0.
  - RUN_CNT=0, SPIKE_CNT=0, BUSY=0, DONE=0, ABORTED=0.
  - Applies mid-sequence with no DONE pulse.
- START sampled at edge t:
  - BUSY=1 and SRC_nRST=0 from t+1 through t+RST_CYC.
  - SRC_nRST=1 and SRC_EN=1 from t+RST_CYC+1.
- Forwarding latency: SRC_DATA sampled at edge k appears on DATA_OUT/DATA_VALID after edge k (1 cycle).
- SRC_END sampled at edge e: SRC_EN=0, RUN_CNT updated, and the new state all take effect after edge e.
- Run-to-run restart period: GAP_CYC + RST_CYC cycles between SRC_EN falling and rising.
- DONE is high exactly one cycle. BUSY falls in the cycle after DONE.

## Test plan
- Single run: NUM_RUNS=1, GAP_CYC=0, source ends after 200 samples.
  - SRC_nRST low 6 cycles, then 200 DATA_VALID cycles with data matching the source, delayed 1 cycle.
  - RUN_CNT=1, one DONE pulse, ABORTED=0.
- Repeat: NUM_RUNS=3, GAP_CYC=10, 50-sample dataset.
  - 3 reset pulses; 16 cycles between each SRC_EN fall and rise.
  - RUN_CNT steps 1,2,3, then DONE.
- Spike counting: 4 SRC_TRGG per run with NUM_RUNS=2 gives SPIKE_CNT=8. With CNT_WIDTH=3, saturates at 7.
- Abort mid-stream: NUM_RUNS=0, ABORT at sample 30 of run 2.
  - FINISH the next cycle, DONE pulse, ABORTED=1, RUN_CNT=1.
  - A following START clears ABORTED and the counters.
- Simultaneous ABORT and SRC_END: RUN_CNT unchanged, ABORTED=1.
- Empty run and reset: SRC_END high on the first STREAM cycle with NUM_RUNS=1.
  - Zero DATA_VALID cycles, RUN_CNT=1, DONE.
  - nRST=0 during STREAM: all outputs return to reset values after that edge, with no DONE pulse.

Source files
------------

// File: rtl/neural_sim_ctrl.sv
// Run scheduler for the dataset replay source: sequences source reset, streaming,
// inter-run gaps and repeat/abort, forwarding samples and counting runs and triggers.
module neural_sim_ctrl #(
  parameter int RST_CYC   = 6,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK_ADC,
  input  logic                 nRST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [7:0]           NUM_RUNS,
  input  logic [15:0]          GAP_CYC,
  input  logic signed [11:0]   SRC_DATA,
  input  logic                 SRC_TRGG,
  input  logic                 SRC_END,
  output logic                 SRC_nRST,
  output logic                 SRC_EN,
  output logic signed [11:0]   DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 TRGG_OUT,
  output logic [7:0]           RUN_CNT,
  output logic [CNT_WIDTH-1:0] SPIKE_CNT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ABORTED
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SRC_RST = 3'd1;
  localparam logic [2:0] ST_STREAM  = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  localparam logic [15:0]          RST_LOAD  = 16'(RST_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] SPIKE_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] SPIKE_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_s;
  logic [7:0]  num_runs_r;
  logic [15:0] gap_cyc_r;
  logic [7:0]  run_inc_s;
  logic        fwd_s;
  logic        run_end_s;
  logic        abort_s;
  logic        start_s;

  // Next-state and phase counter; cnt_r counts down the remaining cycles of SRC_RST or GAP.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    run_inc_s = RUN_CNT + 8'd1;
    fwd_s     = 1'b0;
    run_end_s = 1'b0;
    abort_s   = 1'b0;
    start_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          start_s = 1'b1;
          state_s = ST_SRC_RST;
          cnt_s   = RST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SRC_RST: begin
        if (ABORT) begin
          abort_s = 1'b1;
          state_s = ST_FINISH;
        end else if (cnt_r == 16'd0) begin
          state_s = ST_STREAM;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      ST_STREAM: begin
        fwd_s = ~SRC_END;
        if (ABORT) begin
          abort_s = 1'b1;
          state_s = ST_FINISH;
        end else if (SRC_END) begin
          run_end_s = 1'b1;
          if ((num_runs_r != 8'd0) && (run_inc_s == num_runs_r)) begin
            state_s = ST_FINISH;
          end else if (gap_cyc_r == 16'd0) begin
            state_s = ST_SRC_RST;
            cnt_s   = RST_LOAD;
          end else begin
            state_s = ST_GAP;
            cnt_s   = gap_cyc_r - 16'd1;
          end
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_GAP: begin
        if (ABORT) begin
          abort_s = 1'b1;
          state_s = ST_FINISH;
        end else if (cnt_r == 16'd0) begin
          state_s = ST_SRC_RST;
          cnt_s   = RST_LOAD;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and status outputs, decoded from the next state so they change with it.
  always_ff @(posedge CLK_ADC) begin
    if (!nRST) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 16'd0;
      SRC_nRST <= 1'b0;
      SRC_EN   <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      SRC_nRST <= (state_s == ST_STREAM) || (state_s == ST_GAP);
      SRC_EN   <= (state_s == ST_STREAM);
      BUSY     <= (state_s != ST_IDLE);
      DONE     <= (state_s == ST_FINISH);
    end
  end

  // Sample forwarding, sequence configuration latch and run/trigger counters.
  always_ff @(posedge CLK_ADC) begin
    if (!nRST) begin
      DATA_OUT   <= 12'sd0;
      DATA_VALID <= 1'b0;
      TRGG_OUT   <= 1'b0;
      RUN_CNT    <= 8'd0;
      SPIKE_CNT  <= {CNT_WIDTH{1'b0}};
      ABORTED    <= 1'b0;
      num_runs_r <= 8'd0;
      gap_cyc_r  <= 16'd0;
    end else begin
      DATA_VALID <= fwd_s;
      TRGG_OUT   <= fwd_s & SRC_TRGG;
      if (fwd_s) begin
        DATA_OUT <= SRC_DATA;
      end
      if (start_s) begin
        num_runs_r <= NUM_RUNS;
        gap_cyc_r  <= GAP_CYC;
        RUN_CNT    <= 8'd0;
        SPIKE_CNT  <= {CNT_WIDTH{1'b0}};
        ABORTED    <= 1'b0;
      end else begin
        if (run_end_s) begin
          RUN_CNT <= run_inc_s;
        end
        // The sample on an ABORT cycle is still forwarded, so its trigger still counts.
        if (fwd_s && SRC_TRGG && (SPIKE_CNT != SPIKE_MAX)) begin
          SPIKE_CNT <= SPIKE_CNT + SPIKE_ONE;
        end
        if (abort_s) begin
          ABORTED <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_neural_sim_ctrl.sv
// Self-checking bench for neural_sim_ctrl: a cycle-by-cycle vector table plus
// directed multi-cycle sequences (repeat, abort, empty run, mid-stream reset).
module tb_neural_sim_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               start;
  logic               abort;
  logic [7:0]         num_runs;
  logic [15:0]        gap_cyc;
  logic signed [11:0] src_data;
  logic               src_trgg;
  logic               src_end;

  logic               src_nrst_o, src_en_o, valid_o, trgg_o, busy_o, done_o, aborted_o;
  logic signed [11:0] dout_o;
  logic [7:0]         runs_o;
  logic [15:0]        spikes_o;

  logic               s_src_nrst, s_src_en, s_valid, s_trgg, s_busy, s_done, s_aborted;
  logic signed [11:0] s_dout;
  logic [7:0]         s_runs;
  logic [2:0]         s_spikes;

  neural_sim_ctrl #(.RST_CYC(6), .CNT_WIDTH(16)) dut (
    .CLK_ADC(clk), .nRST(rst_n), .START(start), .ABORT(abort),
    .NUM_RUNS(num_runs), .GAP_CYC(gap_cyc), .SRC_DATA(src_data),
    .SRC_TRGG(src_trgg), .SRC_END(src_end),
    .SRC_nRST(src_nrst_o), .SRC_EN(src_en_o), .DATA_OUT(dout_o),
    .DATA_VALID(valid_o), .TRGG_OUT(trgg_o), .RUN_CNT(runs_o),
    .SPIKE_CNT(spikes_o), .BUSY(busy_o), .DONE(done_o), .ABORTED(aborted_o)
  );

  neural_sim_ctrl #(.RST_CYC(6), .CNT_WIDTH(3)) dut_sat (
    .CLK_ADC(clk), .nRST(rst_n), .START(start), .ABORT(abort),
    .NUM_RUNS(num_runs), .GAP_CYC(gap_cyc), .SRC_DATA(src_data),
    .SRC_TRGG(src_trgg), .SRC_END(src_end),
    .SRC_nRST(s_src_nrst), .SRC_EN(s_src_en), .DATA_OUT(s_dout),
    .DATA_VALID(s_valid), .TRGG_OUT(s_trgg), .RUN_CNT(s_runs),
    .SPIKE_CNT(s_spikes), .BUSY(s_busy), .DONE(s_done), .ABORTED(s_aborted)
  );

  typedef struct {
    logic        start;
    logic        abort;
    logic        src_end;
    logic        trgg;
    logic [11:0] data;
    logic [6:0]  exp_ctrl;   // {SRC_nRST, SRC_EN, DATA_VALID, TRGG_OUT, BUSY, DONE, ABORTED}
    logic [11:0] exp_dout;
    logic [7:0]  exp_runs;
    logic [15:0] exp_spikes;
  } vec_t;

  vec_t tbl [13];

  int n_pass  = 0;
  int n_total = 0;
  int seq     = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Counts cycles until SRC_EN rises (and SRC_nRST-low cycles among them); bounded.
  task automatic wait_en(output int en_low, output int rst_low);
    en_low  = 0;
    rst_low = 0;
    while (src_en_o !== 1'b1 && en_low < 1000) begin
      if (src_nrst_o === 1'b0) rst_low++;
      en_low++;
      tick();
    end
    if (en_low >= 1000) check("src_en_timeout", {31'd0, src_en_o}, 32'd1);
  endtask

  // Feeds n samples (first ntrig carry a trigger), checking each forwarded one cycle later.
  task automatic stream_run(input int n, input int ntrig, input bit with_end, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      src_data = 12'(seq * 37 + 5);
      seq++;
      src_trgg = (i < ntrig);
      src_end  = 1'b0;
      tick();
      if (valid_o !== 1'b1 || dout_o !== src_data || trgg_o !== src_trgg || src_en_o !== 1'b1) bad++;
    end
    src_trgg = 1'b0;
    if (with_end) begin
      src_end = 1'b1;
      tick();
      src_end = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r, bad;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_runs = 8'd1; gap_cyc = 16'd0;
    src_data = 12'sd0; src_trgg = 1'b0; src_end = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 7'b0000100, 12'h000, 8'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 7'b0000100, 12'h000, 8'd0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 7'b0000100, 12'h000, 8'd0, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 7'b0000100, 12'h000, 8'd0, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 7'b0000100, 12'h000, 8'd0, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 7'b0000100, 12'h000, 8'd0, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 7'b1100100, 12'h000, 8'd0, 16'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 7'b1111100, 12'h123, 8'd0, 16'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'hABC, 7'b1110100, 12'hABC, 8'd0, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h7FF, 7'b1111100, 12'h7FF, 8'd0, 16'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h555, 7'b0000110, 12'h7FF, 8'd1, 16'd2};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 7'b0000000, 12'h7FF, 8'd1, 16'd2};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 7'b0000000, 12'h7FF, 8'd1, 16'd2};

    tick(); tick();
    check("reset_ctrl", {25'd0, src_nrst_o, src_en_o, valid_o, trgg_o, busy_o, done_o, aborted_o}, 32'd0);
    check("reset_data", {12'd0, dout_o, runs_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Short single run applied cycle by cycle (START in FINISH and ABORT in IDLE ignored).
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].start; abort = tbl[i].abort; src_end = tbl[i].src_end;
      src_trgg = tbl[i].trgg; src_data = tbl[i].data;
      tick();
      check($sformatf("vec%0d_ctrl", i),
            {25'd0, src_nrst_o, src_en_o, valid_o, trgg_o, busy_o, done_o, aborted_o},
            {25'd0, tbl[i].exp_ctrl});
      check($sformatf("vec%0d_data", i), {12'd0, dout_o, runs_o}, {12'd0, tbl[i].exp_dout, tbl[i].exp_runs});
      check($sformatf("vec%0d_spikes", i), {16'd0, spikes_o}, {16'd0, tbl[i].exp_spikes});
    end
    start = 1'b0; abort = 1'b0; src_end = 1'b0; src_trgg = 1'b0;
    tick();

    // Single run of 200 samples.
    num_runs = 8'd1; gap_cyc = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    wait_en(c, r);
    check("single_rst_len", r, 32'd6);
    stream_run(200, 0, 1'b1, bad);
    check("single_stream_bad", bad, 32'd0);
    check("single_done", {31'd0, done_o}, 32'd1);
    check("single_runs", {24'd0, runs_o}, 32'd1);
    tick();
    check("single_done_fall", {30'd0, done_o, busy_o}, 32'd0);
    check("single_aborted", {31'd0, aborted_o}, 32'd0);

    // Three runs with a 10-cycle gap, four triggers per run.
    num_runs = 8'd3; gap_cyc = 16'd10;
    start = 1'b1; tick(); start = 1'b0;
    wait_en(c, r);
    check("repeat_rst_len0", r, 32'd6);
    for (int k = 1; k <= 3; k++) begin
      stream_run(50, 4, 1'b1, bad);
      check($sformatf("repeat_bad%0d", k), bad, 32'd0);
      check($sformatf("repeat_runs%0d", k), {24'd0, runs_o}, k);
      if (k < 3) begin
        check($sformatf("repeat_busy%0d", k), {30'd0, busy_o, done_o}, 32'd2);
        wait_en(c, r);
        check($sformatf("repeat_restart%0d", k), c, 32'd16);
        check($sformatf("repeat_rst_len%0d", k), r, 32'd6);
      end else begin
        check("repeat_done", {31'd0, done_o}, 32'd1);
      end
    end
    tick();
    check("repeat_idle", {31'd0, busy_o}, 32'd0);
    check("repeat_spikes", {16'd0, spikes_o}, 32'd12);
    check("repeat_spikes_sat", {29'd0, s_spikes}, 32'd7);

    // Continuous mode, ABORT on sample 30 of run 2.
    num_runs = 8'd0; gap_cyc = 16'd3;
    start = 1'b1; tick(); start = 1'b0;
    wait_en(c, r);
    stream_run(20, 1, 1'b1, bad);
    check("abort_run1_runs", {24'd0, runs_o}, 32'd1);
    wait_en(c, r);
    check("abort_restart", c, 32'd9);
    stream_run(29, 0, 1'b0, bad);
    check("abort_stream_bad", bad, 32'd0);
    src_data = 12'h2A5; abort = 1'b1; tick(); abort = 1'b0;
    check("abort_finish", {29'd0, done_o, valid_o, aborted_o}, 32'd7);
    check("abort_last_sample", {20'd0, dout_o}, 32'h2A5);
    check("abort_runs", {24'd0, runs_o}, 32'd1);
    tick();
    check("abort_idle", {30'd0, busy_o, aborted_o}, 32'd1);
    check("abort_spikes_kept", {16'd0, spikes_o}, 32'd1);

    // Restart clears status, then ABORT together with SRC_END.
    num_runs = 8'd1; gap_cyc = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    check("restart_cleared", {15'd0, aborted_o, runs_o, spikes_o[7:0]}, 32'd0);
    wait_en(c, r);
    stream_run(5, 0, 1'b0, bad);
    src_end = 1'b1; abort = 1'b1; tick(); src_end = 1'b0; abort = 1'b0;
    check("abort_end_flags", {29'd0, done_o, valid_o, aborted_o}, 32'd5);
    check("abort_end_runs", {24'd0, runs_o}, 32'd0);
    tick();

    // Empty run: SRC_END already high on the first STREAM cycle.
    start = 1'b1; tick(); start = 1'b0;
    wait_en(c, r);
    src_end = 1'b1; tick(); src_end = 1'b0;
    check("empty_flags", {30'd0, valid_o, done_o}, 32'd1);
    check("empty_runs", {24'd0, runs_o}, 32'd1);
    tick();

    // Reset while streaming.
    start = 1'b1; tick(); start = 1'b0;
    wait_en(c, r);
    stream_run(3, 3, 1'b0, bad);
    check("prereset_spikes", {16'd0, spikes_o}, 32'd3);
    rst_n = 1'b0; tick();
    check("midreset_ctrl", {25'd0, src_nrst_o, src_en_o, valid_o, trgg_o, busy_o, done_o, aborted_o}, 32'd0);
    check("midreset_data", {12'd0, dout_o, runs_o}, 32'd0);
    check("midreset_spikes", {16'd0, spikes_o}, 32'd0);
    rst_n = 1'b1; tick();
    check("postreset_idle", {30'd0, busy_o, done_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
